// File: rtl/dm_port_arbiter.sv
// Single-port data-memory arbiter between the core MEM path and a host loader/debug port.
// Core has priority; a host that has been denied MAX_WAIT cycles in a row wins the next conflict.
module dm_port_arbiter #(
    parameter int AW       = 9,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_in,
    output logic          dm_w,
    output logic          dm_en,
    input  logic [DW-1:0] dm_out,
    output logic [3:0]    host_wait
);

    typedef enum logic [1:0] {NONE = 2'd0, CORE = 2'd1, HOST = 2'd2} owner_t;

    owner_t     rd_owner;
    logic [3:0] wait_cnt;
    logic       core_win;
    logic       host_win;
    logic       host_starved;

    assign host_starved = (wait_cnt == 4'(MAX_WAIT));

    // Grants are suppressed while reset is held so the memory sees no stray strobe.
    always_comb begin
        core_win = 1'b0;
        host_win = 1'b0;
        if (rst) begin
            if (host_req && (!core_req || host_starved))
                host_win = 1'b1;
            else if (core_req)
                core_win = 1'b1;
        end
    end

    assign core_gnt = core_win;
    assign host_gnt = host_win;
    assign dm_en    = core_win | host_win;
    assign dm_w     = (core_win & core_we) | (host_win & host_we);
    assign dm_addr  = host_win ? host_addr  : (core_win ? core_addr  : '0);
    assign dm_in    = host_win ? host_wdata : (core_win ? core_wdata : '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 4'd0;
            rd_owner <= NONE;
        end else begin
            if (host_req && !host_win)
                wait_cnt <= host_starved ? wait_cnt : wait_cnt + 4'd1;
            else
                wait_cnt <= 4'd0;

            if (core_win && !core_we)
                rd_owner <= CORE;
            else if (host_win && !host_we)
                rd_owner <= HOST;
            else
                rd_owner <= NONE;
        end
    end

    assign host_wait   = wait_cnt;
    assign core_rvalid = (rd_owner == CORE);
    assign host_rvalid = (rd_owner == HOST);
    assign core_rdata  = core_rvalid ? dm_out : '0;
    assign host_rdata  = host_rvalid ? dm_out : '0;

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single-port data memory (9-bit address, 16-bit data) between two requesters: the core's MEM-phase load/store/stack path, and a host loader/debug port that preloads or inspects data memory.
- Grants at most one access per clock. The core has priority, but the host is never starved beyond a bounded wait.
- Drives the data-memory address, data-in and write-enable. Routes the registered read data back to the requester that issued the read.

Parameters:
- AW, 9, data-memory address width.
- DW, 16, data width.
- MAX_WAIT, 4, consecutive denied host cycles after which the host wins a conflict (1..15).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- core_req  in  1  core access request; held until core_gnt.
- core_we  in  1  1 = store/push, 0 = load/pop.
- core_addr  in  AW  core address (immediate or SP).
- core_wdata  in  DW  core store data.
- core_gnt  out  1  access issued this cycle.
- core_rvalid  out  1  core read data valid.
- core_rdata  out  DW  core read data.
- host_req  in  1  host access request; held until host_gnt.
- host_we  in  1  host write enable.
- host_addr  in  AW  host address.
- host_wdata  in  DW  host write data.
- host_gnt  out  1  access issued this cycle.
- host_rvalid  out  1  host read data valid.
- host_rdata  out  DW  host read data.
- dm_addr  out  AW  memory address.
- dm_in  out  DW  memory write data.
- dm_w  out  1  memory write strobe.
- dm_en  out  1  memory access strobe.
- dm_out  in  DW  memory read data, registered one cycle after dm_en.
- host_wait  out  4  current host starvation count (debug).

Behaviour:
- Reset (rst=0, asynchronous):
  - wait_cnt=0, rd_owner=NONE, host_wait=0.
  - All gnt/rvalid=0, rdata=0, dm_w=0, dm_en=0, dm_addr=0, dm_in=0.
- Arbitration is combinational within the cycle:
  - Core alone requesting: core wins.
  - Host alone requesting: host wins.
  - Both requesting: core wins unless wait_cnt==MAX_WAIT, in which case host wins.
- Winner outputs:
  - Winner's gnt=1 and dm_en=1.
  - dm_addr/dm_in/dm_w are copied from the winner; dm_w = winner's we.
- No request: dm_en=0, dm_w=0, dm_addr/dm_in hold 0.
- wait_cnt register:
  - If host_req=1 and host_gnt=0: wait_cnt increments, saturating at MAX_WAIT.
  - If host_gnt=1 or host_req=0: wait_cnt is cleared to 0.
  - host_wait mirrors wait_cnt.
- rd_owner register (state machine NONE / CORE / HOST):
  - On a read grant (gnt=1, we=0), the next state is CORE or HOST according to the winner.
  - Otherwise the next state is NONE.
- Read return:
  - In state CORE: core_rvalid=1 and core_rdata=dm_out. Same for HOST.
  - Non-owner rvalid=0 and its rdata=0.
- Latency:
  - Grant is same-cycle.
  - Read data arrives exactly one cycle after the grant.
  - Writes complete in the grant cycle and produce no response.
- Back-to-back: a new grant may issue in the same cycle an earlier read returns. Full throughput is one access per clock.
- Ordering: accesses take effect in grant order.
  - Host write to address A granted in cycle n, then core read of A in cycle n+1: the core read returns the new value.
- Requesters must hold req/we/addr/wdata stable until gnt. A request dropped before gnt is abandoned with no side effect.
- Reset mid-read: a pending rvalid is discarded and does not appear after reset release.
- Requests in the first cycle after rst deasserts are arbitrated normally.

Test Plan:
- Core-only read: core_req=1, core_we=0, core_addr=0x005, with DM[5]=0x1234 → core_gnt=1 and dm_en=1 at cycle n; core_rvalid=1 and core_rdata=0x1234 at n+1; host_rvalid=0 throughout.
- Host write then core read of the same address: host writes 0xBEEF to address 0x1FF at cycle n; core reads 0x1FF at n+1 → core_rdata=0xBEEF at n+2.
- Continuous contention with MAX_WAIT=4 (both requesting every cycle, core re-requesting immediately after each grant):
  - Core granted cycles 0-3; host_wait counts 1, 2, 3, 4.
  - Host granted at cycle 4; host_wait=0 at cycle 5; core granted at cycle 5.
- Back-to-back reads: core reads address 1, then host reads address 2 on consecutive cycles → core_rvalid at n+1 and host_rvalid at n+2, with correct data and no cross-routing.
- Host drops request: host_req pulses for 2 cycles while the core holds the port → no host_gnt, no dm_w, and host_wait returns to 0.
- Reset mid-read: core read granted at cycle n, rst=0 asynchronously before the n+1 edge → all outputs 0 immediately, and no rvalid after rst returns to 1.
